// File: rtl/match_flow_controller_if.sv
// Bus between the button decoder / game logic and the match flow controller.
// PAUSE_EN adds the pause_btn input.
interface match_flow_controller_if;
  logic       frame_tick;
  logic       start_btn;
  logic       mode_sel;
  logic       p1_ko;
  logic       p2_ko;
`ifdef PAUSE_EN
  logic       pause_btn;
`endif
  logic       game_mode;
  logic       input_enable;
  logic       char_reset;
  logic [2:0] state;
  logic [1:0] countdown_sec;
  logic [6:0] timer_sec;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  modport master (
`ifdef PAUSE_EN
    output pause_btn,
`endif
    output frame_tick, start_btn, mode_sel, p1_ko, p2_ko,
    input  game_mode, input_enable, char_reset, state, countdown_sec,
    input  timer_sec, p1_rounds, p2_rounds, round_winner, match_winner
  );

  modport slave (
`ifdef PAUSE_EN
    input  pause_btn,
`endif
    input  frame_tick, start_btn, mode_sel, p1_ko, p2_ko,
    output game_mode, input_enable, char_reset, state, countdown_sec,
    output timer_sec, p1_rounds, p2_rounds, round_winner, match_winner
  );
endinterface

// File: rtl/match_flow_controller.sv
// Match sequencer: menu, countdown, fight, round result, match result.
// Optional PAUSE_EN macro adds a pause button and PAUSED state (code 5).
module match_flow_controller #(
  parameter int FPS           = 60,
  parameter int COUNTDOWN_SEC = 3,
  parameter int ROUND_SEC     = 60,
  parameter int RESULT_FRAMES = 120,
  parameter int ROUNDS_TO_WIN = 2
) (
  input logic                    clk,
  input logic                    reset,
  match_flow_controller_if.slave bus
);
  localparam int FC_MAX = (FPS > RESULT_FRAMES) ? FPS : RESULT_FRAMES;
  localparam int FC_W   = $clog2(FC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    FIGHT     = 3'd2,
    ROUND_END = 3'd3,
    MATCH_END = 3'd4
`ifdef PAUSE_EN
    ,PAUSED   = 3'd5
`endif
  } state_e;

  state_e          state_q, state_d;
  logic            game_mode_q, game_mode_d;
  logic            input_enable_q, input_enable_d;
  logic            char_reset_q, char_reset_d;
  logic [1:0]      countdown_sec_q, countdown_sec_d;
  logic [6:0]      timer_sec_q, timer_sec_d;
  logic [1:0]      p1_rounds_q, p1_rounds_d;
  logic [1:0]      p2_rounds_q, p2_rounds_d;
  logic [1:0]      round_winner_q, round_winner_d;
  logic [1:0]      match_winner_q, match_winner_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            start_prev_q, start_prev_d;
  logic            start_evt_q, start_evt_d;
`ifdef PAUSE_EN
  logic            pause_prev_q, pause_prev_d;
  logic            pause_evt_q, pause_evt_d;
`endif
  logic            sec_wrap;
  logic            round_done;

  assign sec_wrap = (frame_cnt_q == FC_W'(FPS - 1));

  always_comb begin
    state_d         = state_q;
    game_mode_d     = game_mode_q;
    countdown_sec_d = countdown_sec_q;
    timer_sec_d     = timer_sec_q;
    p1_rounds_d     = p1_rounds_q;
    p2_rounds_d     = p2_rounds_q;
    round_winner_d  = round_winner_q;
    match_winner_d  = match_winner_q;
    frame_cnt_d     = frame_cnt_q;
    round_done      = 1'b0;
    start_prev_d    = bus.start_btn;
    start_evt_d     = bus.start_btn & ~start_prev_q;
`ifdef PAUSE_EN
    pause_prev_d    = bus.pause_btn;
    pause_evt_d     = bus.pause_btn & ~pause_prev_q;
`endif

    case (state_q)
      IDLE: if (start_evt_q) begin
        game_mode_d     = bus.mode_sel;
        p1_rounds_d     = 2'd0;
        p2_rounds_d     = 2'd0;
        match_winner_d  = 2'd0;
        countdown_sec_d = 2'(COUNTDOWN_SEC);
        frame_cnt_d     = '0;
        state_d         = COUNTDOWN;
      end
      COUNTDOWN: if (bus.frame_tick) begin
        if (sec_wrap) begin
          frame_cnt_d     = '0;
          countdown_sec_d = countdown_sec_q - 2'd1;
          if (countdown_sec_q == 2'd1) begin
            timer_sec_d    = 7'(ROUND_SEC);
            round_winner_d = 2'd0;
            state_d        = FIGHT;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      FIGHT: begin
`ifdef PAUSE_EN
        if (pause_evt_q) state_d = PAUSED;
        else
`endif
        if (bus.frame_tick) begin
          frame_cnt_d = sec_wrap ? '0 : frame_cnt_q + 1'b1;
          if (sec_wrap) timer_sec_d = timer_sec_q - 7'd1;
          // KO outranks a time-out landing on the same tick.
          round_done = 1'b1;
          if (bus.p1_ko && bus.p2_ko) begin
            round_winner_d = 2'b11;
          end else if (bus.p2_ko) begin
            round_winner_d = 2'b01;
            p1_rounds_d    = (p1_rounds_q == 2'd3) ? 2'd3 : p1_rounds_q + 2'd1;
          end else if (bus.p1_ko) begin
            round_winner_d = 2'b10;
            p2_rounds_d    = (p2_rounds_q == 2'd3) ? 2'd3 : p2_rounds_q + 2'd1;
          end else if (sec_wrap && timer_sec_q == 7'd1) begin
            round_winner_d = 2'b11;
          end else begin
            round_done = 1'b0;
          end
          if (round_done) begin
            frame_cnt_d = '0;
            state_d     = ROUND_END;
          end
        end
      end
      ROUND_END: if (bus.frame_tick) begin
        if (frame_cnt_q == FC_W'(RESULT_FRAMES - 1)) begin
          frame_cnt_d = '0;
          if (p1_rounds_q == 2'(ROUNDS_TO_WIN)) begin
            match_winner_d = 2'b01;
            state_d        = MATCH_END;
          end else if (p2_rounds_q == 2'(ROUNDS_TO_WIN)) begin
            match_winner_d = 2'b10;
            state_d        = MATCH_END;
          end else begin
            countdown_sec_d = 2'(COUNTDOWN_SEC);
            state_d         = COUNTDOWN;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      MATCH_END: if (start_evt_q) state_d = IDLE;
`ifdef PAUSE_EN
      PAUSED: if (pause_evt_q) state_d = FIGHT;
`endif
      default: state_d = IDLE;
    endcase

    // Gating outputs follow the next state so they change with the state code.
    input_enable_d = (state_d == FIGHT);
    char_reset_d   = (state_d == IDLE) || (state_d == COUNTDOWN) || (state_d == MATCH_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      game_mode_q     <= 1'b0;
      input_enable_q  <= 1'b0;
      char_reset_q    <= 1'b1;
      countdown_sec_q <= 2'd0;
      timer_sec_q     <= 7'd0;
      p1_rounds_q     <= 2'd0;
      p2_rounds_q     <= 2'd0;
      round_winner_q  <= 2'd0;
      match_winner_q  <= 2'd0;
      frame_cnt_q     <= '0;
      start_prev_q    <= 1'b0;
      start_evt_q     <= 1'b0;
`ifdef PAUSE_EN
      pause_prev_q    <= 1'b0;
      pause_evt_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      game_mode_q     <= game_mode_d;
      input_enable_q  <= input_enable_d;
      char_reset_q    <= char_reset_d;
      countdown_sec_q <= countdown_sec_d;
      timer_sec_q     <= timer_sec_d;
      p1_rounds_q     <= p1_rounds_d;
      p2_rounds_q     <= p2_rounds_d;
      round_winner_q  <= round_winner_d;
      match_winner_q  <= match_winner_d;
      frame_cnt_q     <= frame_cnt_d;
      start_prev_q    <= start_prev_d;
      start_evt_q     <= start_evt_d;
`ifdef PAUSE_EN
      pause_prev_q    <= pause_prev_d;
      pause_evt_q     <= pause_evt_d;
`endif
    end
  end

  assign bus.state         = state_q;
  assign bus.game_mode     = game_mode_q;
  assign bus.input_enable  = input_enable_q;
  assign bus.char_reset    = char_reset_q;
  assign bus.countdown_sec = countdown_sec_q;
  assign bus.timer_sec     = timer_sec_q;
  assign bus.p1_rounds     = p1_rounds_q;
  assign bus.p2_rounds     = p2_rounds_q;
  assign bus.round_winner  = round_winner_q;
  assign bus.match_winner  = match_winner_q;
endmodule

// File: tb/tb_match_flow_controller.sv
// Directed bench for match_flow_controller with default parameters.
module tb_match_flow_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  match_flow_controller_if bus ();
  match_flow_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk) bus.start_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic ko_tick(input logic k1, input logic k2);
    @(negedge clk) begin bus.p1_ko = k1; bus.p2_ko = k2; bus.frame_tick = 1'b1; end
    @(negedge clk) begin bus.p1_ko = 1'b0; bus.p2_ko = 1'b0; bus.frame_tick = 1'b0; end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    checks++; if (bus.char_reset !== 1'b1) begin errors++; $display("FAIL rst_char_reset got %0b exp 1", bus.char_reset); end
    checks++; if ({bus.input_enable, bus.game_mode, bus.countdown_sec, bus.timer_sec, bus.p1_rounds, bus.p2_rounds, bus.round_winner, bus.match_winner} !== 17'd0)
      begin errors++; $display("FAIL rst_outputs got nonzero exp all zero"); end
    @(negedge clk) reset = 1'b0;
    ticks(3);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_no_start got %0d exp 0", bus.state); end
  endtask

  task automatic test_countdown();
    bus.mode_sel = 1'b1;
    press_start();
    bus.mode_sel = 1'b0;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL cd_state got %0d exp 1", bus.state); end
    checks++; if (bus.game_mode !== 1'b1) begin errors++; $display("FAIL cd_game_mode got %0b exp 1", bus.game_mode); end
    checks++; if (bus.countdown_sec !== 2'd3) begin errors++; $display("FAIL cd_sec3 got %0d exp 3", bus.countdown_sec); end
    ticks(59);
    checks++; if (bus.countdown_sec !== 2'd3) begin errors++; $display("FAIL cd_sec3_t59 got %0d exp 3", bus.countdown_sec); end
    ticks(1);
    checks++; if (bus.countdown_sec !== 2'd2) begin errors++; $display("FAIL cd_sec2 got %0d exp 2", bus.countdown_sec); end
    ticks(60);
    checks++; if (bus.countdown_sec !== 2'd1) begin errors++; $display("FAIL cd_sec1 got %0d exp 1", bus.countdown_sec); end
    ticks(59);
    checks++; if (bus.state !== 3'd1 || bus.input_enable !== 1'b0 || bus.char_reset !== 1'b1)
      begin errors++; $display("FAIL cd_t179 got state %0d ie %0b cr %0b exp 1 0 1", bus.state, bus.input_enable, bus.char_reset); end
    ticks(1);
    checks++; if (bus.state !== 3'd2 || bus.timer_sec !== 7'd60) begin errors++; $display("FAIL fight_entry got state %0d timer %0d exp 2 60", bus.state, bus.timer_sec); end
    checks++; if (bus.input_enable !== 1'b1 || bus.char_reset !== 1'b0) begin errors++; $display("FAIL fight_gating got ie %0b cr %0b exp 1 0", bus.input_enable, bus.char_reset); end
    checks++; if (bus.game_mode !== 1'b1) begin errors++; $display("FAIL mode_hold got %0b exp 1", bus.game_mode); end
  endtask

  task automatic test_ko_round();
    ticks(60);
    checks++; if (bus.timer_sec !== 7'd59) begin errors++; $display("FAIL timer_59 got %0d exp 59", bus.timer_sec); end
    ko_tick(1'b0, 1'b1);
    checks++; if (bus.state !== 3'd3 || bus.round_winner !== 2'b01 || bus.p1_rounds !== 2'd1)
      begin errors++; $display("FAIL p2_ko got state %0d rw %0d p1 %0d exp 3 1 1", bus.state, bus.round_winner, bus.p1_rounds); end
    checks++; if (bus.input_enable !== 1'b0 || bus.char_reset !== 1'b0) begin errors++; $display("FAIL re_gating got ie %0b cr %0b exp 0 0", bus.input_enable, bus.char_reset); end
    ticks(119);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL re_t119 got %0d exp 3", bus.state); end
    ticks(1);
    checks++; if (bus.state !== 3'd1 || bus.countdown_sec !== 2'd3) begin errors++; $display("FAIL re_to_cd got state %0d cd %0d exp 1 3", bus.state, bus.countdown_sec); end
    ticks(180);
  endtask

  task automatic test_timeout();
    ticks(3599);
    checks++; if (bus.state !== 3'd2 || bus.timer_sec !== 7'd1) begin errors++; $display("FAIL to_t3599 got state %0d timer %0d exp 2 1", bus.state, bus.timer_sec); end
    ticks(1);
    checks++; if (bus.state !== 3'd3 || bus.timer_sec !== 7'd0 || bus.round_winner !== 2'b11)
      begin errors++; $display("FAIL timeout got state %0d timer %0d rw %0d exp 3 0 3", bus.state, bus.timer_sec, bus.round_winner); end
    checks++; if (bus.p1_rounds !== 2'd1 || bus.p2_rounds !== 2'd0) begin errors++; $display("FAIL to_score got %0d %0d exp 1 0", bus.p1_rounds, bus.p2_rounds); end
    ticks(300);
  endtask

  task automatic test_double_ko_and_expiry();
    checks++; if (bus.state !== 3'd2 || bus.round_winner !== 2'b00) begin errors++; $display("FAIL rw_clear got state %0d rw %0d exp 2 0", bus.state, bus.round_winner); end
    press_start();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_ignored got %0d exp 2", bus.state); end
    ko_tick(1'b1, 1'b1);
    checks++; if (bus.round_winner !== 2'b11 || bus.p1_rounds !== 2'd1 || bus.p2_rounds !== 2'd0)
      begin errors++; $display("FAIL double_ko got rw %0d p1 %0d p2 %0d exp 3 1 0", bus.round_winner, bus.p1_rounds, bus.p2_rounds); end
    ticks(300);
    ticks(3599);
    ko_tick(1'b1, 1'b0);
    checks++; if (bus.state !== 3'd3 || bus.round_winner !== 2'b10 || bus.p2_rounds !== 2'd1)
      begin errors++; $display("FAIL ko_at_expiry got state %0d rw %0d p2 %0d exp 3 2 1", bus.state, bus.round_winner, bus.p2_rounds); end
    ticks(120);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL one_one_cd got %0d exp 1", bus.state); end
  endtask

  task automatic test_match_end();
    ticks(180);
    ko_tick(1'b0, 1'b1);
    checks++; if (bus.p1_rounds !== 2'd2) begin errors++; $display("FAIL p1_two got %0d exp 2", bus.p1_rounds); end
    ticks(120);
    checks++; if (bus.state !== 3'd4 || bus.match_winner !== 2'b01) begin errors++; $display("FAIL match_end got state %0d mw %0d exp 4 1", bus.state, bus.match_winner); end
    checks++; if (bus.char_reset !== 1'b1 || bus.input_enable !== 1'b0) begin errors++; $display("FAIL me_gating got cr %0b ie %0b exp 1 0", bus.char_reset, bus.input_enable); end
    ticks(50);
    checks++; if (bus.state !== 3'd4 || bus.p1_rounds !== 2'd2) begin errors++; $display("FAIL me_hold got state %0d p1 %0d exp 4 2", bus.state, bus.p1_rounds); end
    press_start();
    checks++; if (bus.state !== 3'd0 || bus.char_reset !== 1'b1) begin errors++; $display("FAIL to_idle got state %0d cr %0b exp 0 1", bus.state, bus.char_reset); end
    bus.mode_sel = 1'b0;
    press_start();
    checks++; if (bus.state !== 3'd1 || bus.p1_rounds !== 2'd0 || bus.p2_rounds !== 2'd0 || bus.match_winner !== 2'd0)
      begin errors++; $display("FAIL rematch_clear got state %0d p1 %0d p2 %0d mw %0d exp 1 0 0 0", bus.state, bus.p1_rounds, bus.p2_rounds, bus.match_winner); end
    checks++; if (bus.game_mode !== 1'b0) begin errors++; $display("FAIL rematch_mode got %0b exp 0", bus.game_mode); end
  endtask

`ifdef PAUSE_EN
  task automatic test_pause();
    ticks(180);
    ticks(60);
    @(negedge clk) bus.pause_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.pause_btn = 1'b0;
    checks++; if (bus.state !== 3'd5 || bus.input_enable !== 1'b0) begin errors++; $display("FAIL paused got state %0d ie %0b exp 5 0", bus.state, bus.input_enable); end
    bus.p1_ko = 1'b1;
    ticks(500);
    bus.p1_ko = 1'b0;
    checks++; if (bus.state !== 3'd5 || bus.timer_sec !== 7'd59) begin errors++; $display("FAIL pause_hold got state %0d timer %0d exp 5 59", bus.state, bus.timer_sec); end
    @(negedge clk) bus.pause_btn = 1'b1;
    @(negedge clk);
    @(negedge clk) bus.pause_btn = 1'b0;
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL resume got %0d exp 2", bus.state); end
    ticks(60);
    checks++; if (bus.timer_sec !== 7'd58) begin errors++; $display("FAIL resume_timer got %0d exp 58", bus.timer_sec); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    bus.mode_sel = 1'b0;
    press_start();
  endtask
`endif

  task automatic test_reset_mid_fight();
    ticks(180);
    ticks(30);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL pre_rst_fight got %0d exp 2", bus.state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.timer_sec !== 7'd0 || bus.char_reset !== 1'b1 || bus.input_enable !== 1'b0)
      begin errors++; $display("FAIL async_rst got state %0d timer %0d cr %0b ie %0b exp 0 0 1 0", bus.state, bus.timer_sec, bus.char_reset, bus.input_enable); end
    checks++; if (bus.round_winner !== 2'd0 || bus.countdown_sec !== 2'd0) begin errors++; $display("FAIL async_rst_misc got rw %0d cd %0d exp 0 0", bus.round_winner, bus.countdown_sec); end
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.mode_sel   = 1'b0;
    bus.p1_ko      = 1'b0;
    bus.p2_ko      = 1'b0;
`ifdef PAUSE_EN
    bus.pause_btn  = 1'b0;
`endif
    test_reset();
    test_countdown();
    test_ko_round();
    test_timeout();
    test_double_ko_and_expiry();
    test_match_end();
`ifdef PAUSE_EN
    test_pause();
`endif
    test_reset_mid_fight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
